// File: rtl/acondicionador_pulsadores.sv
`default_nettype none
// ============================================================================
// Module   : acondicionador_pulsadores
// Purpose  : Conditions raw board push-buttons for the mode controller.
//            Each channel is synchronised (2 FF), polarity-normalised,
//            debounced, and turned into a held level, a press pulse with
//            optional auto-repeat, and a release pulse.
// Ports    : clk      - board clock, single clock domain
//            reset    - asynchronous reset, active low
//            botones  - raw button pins, asynchronous to clk
//            nivel    - debounced pressed state (1 = pressed)
//            pulso    - one-cycle pulse on accepted press and on auto-repeat
//            soltar   - one-cycle pulse on accepted release
// Revision : 1.0 - initial release
// ============================================================================
module acondicionador_pulsadores #(
  parameter int                   N_BOTONES       = 4,
  parameter bit                   ACTIVO_BAJO     = 1'b1,
  parameter int                   DEBOUNCE_CICLOS = 1000000,
  parameter int                   REPETIR_RETARDO = 25000000,
  parameter int                   REPETIR_PERIODO = 10000000,
  parameter logic [N_BOTONES-1:0] REPETIR_MASK    = N_BOTONES'(4'b0011)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BOTONES-1:0] botones,
  output logic [N_BOTONES-1:0] nivel,
  output logic [N_BOTONES-1:0] pulso,
  output logic [N_BOTONES-1:0] soltar
);

  // Debounce counter runs 0 .. DEBOUNCE_CICLOS-1.
  localparam int C_CNT_W = $clog2(DEBOUNCE_CICLOS);
  localparam logic [C_CNT_W-1:0] C_CNT_FIN = C_CNT_W'(DEBOUNCE_CICLOS - 1);

  localparam int C_REP_MAX = (REPETIR_RETARDO > REPETIR_PERIODO) ?
                             REPETIR_RETARDO : REPETIR_PERIODO;
  localparam int C_REP_W   = $clog2(C_REP_MAX + 1);
  localparam logic [C_REP_W-1:0] C_REP_RET = C_REP_W'(REPETIR_RETARDO);
  localparam logic [C_REP_W-1:0] C_REP_PER = C_REP_W'(REPETIR_PERIODO);

  // Synchroniser flops come out of reset at the released pin level so a
  // button that is not pressed never looks like an edge after reset.
  localparam logic [1:0] C_SYNC_REPOSO = ACTIVO_BAJO ? 2'b11 : 2'b00;

  for (genvar gi = 0; gi < N_BOTONES; gi++) begin : g_canal
    logic [1:0]         sync_q;
    logic               w_s;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic               nivel_q, nivel_d;
    logic               pulso_q, pulso_d;
    logic               soltar_q, soltar_d;
    logic               w_disparo;

    // Pressed = 1 regardless of board polarity.
    assign w_s = ACTIVO_BAJO ? ~sync_q[1] : sync_q[1];

    always_comb begin
      cnt_d   = cnt_q;
      nivel_d = nivel_q;
      if (w_s == nivel_q) begin
        cnt_d = '0;
      end else if (cnt_q == C_CNT_FIN) begin
        nivel_d = w_s;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Pulses are derived from the next level so they line up with the first
    // cycle in which nivel shows the new value. A repeat can only fire while
    // the level stays high across the edge, so it never meets soltar.
    always_comb begin
      pulso_d  = (nivel_d & ~nivel_q) | w_disparo;
      soltar_d = ~nivel_d & nivel_q;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q   <= C_SYNC_REPOSO;
        cnt_q    <= '0;
        nivel_q  <= 1'b0;
        pulso_q  <= 1'b0;
        soltar_q <= 1'b0;
      end else begin
        sync_q   <= {sync_q[0], botones[gi]};
        cnt_q    <= cnt_d;
        nivel_q  <= nivel_d;
        pulso_q  <= pulso_d;
        soltar_q <= soltar_d;
      end
    end

    if (REPETIR_MASK[gi]) begin : g_rep
      logic [C_REP_W-1:0] rep_q, rep_d, w_rep_inc;
      logic               fase_q, fase_d;

      // rep_q counts cycles since the last pulse (press or repeat). The
      // pulse is registered, so it fires on the edge where the incremented
      // count reaches the target; the count then restarts from zero, which
      // keeps it bounded by the larger of the two intervals.
      always_comb begin
        rep_d     = rep_q;
        fase_d    = fase_q;
        w_disparo = 1'b0;
        w_rep_inc = rep_q + 1'b1;
        if (!(nivel_q && nivel_d)) begin
          rep_d  = '0;
          fase_d = 1'b0;
        end else if (w_rep_inc == (fase_q ? C_REP_PER : C_REP_RET)) begin
          w_disparo = 1'b1;
          rep_d     = '0;
          fase_d    = 1'b1;
        end else begin
          rep_d = w_rep_inc;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rep_q  <= '0;
          fase_q <= 1'b0;
        end else begin
          rep_q  <= rep_d;
          fase_q <= fase_d;
        end
      end
    end else begin : g_sin_rep
      assign w_disparo = 1'b0;
    end

    assign nivel[gi]  = nivel_q;
    assign pulso[gi]  = pulso_q;
    assign soltar[gi] = soltar_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_acondicionador_pulsadores.sv
`default_nettype none
// ============================================================================
// Module   : tb_acondicionador_pulsadores
// Purpose  : Directed self-checking bench for acondicionador_pulsadores with
//            DEBOUNCE_CICLOS=4, REPETIR_RETARDO=10, REPETIR_PERIODO=5,
//            REPETIR_MASK=4'b0011, active-low buttons.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acondicionador_pulsadores;

  logic       clk     = 1'b0;
  logic       reset   = 1'b0;
  logic [3:0] botones = 4'hF;
  logic [3:0] nivel;
  logic [3:0] pulso;
  logic [3:0] soltar;

  int nchecks = 0;
  int npass   = 0;

  acondicionador_pulsadores #(
    .N_BOTONES      (4),
    .ACTIVO_BAJO    (1'b1),
    .DEBOUNCE_CICLOS(4),
    .REPETIR_RETARDO(10),
    .REPETIR_PERIODO(5),
    .REPETIR_MASK   (4'b0011)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .botones(botones),
    .nivel  (nivel),
    .pulso  (pulso),
    .soltar (soltar)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and move 1 ns past it; iteration i of a loop
  // that calls this once per pass observes the state after edge i.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    botones = 4'hF;
    #2;
    nchecks++; if (nivel  !== 4'h0) $display("FAIL reset_nivel got=%b exp=0000", nivel);  else npass++;
    nchecks++; if (pulso  !== 4'h0) $display("FAIL reset_pulso got=%b exp=0000", pulso);  else npass++;
    nchecks++; if (soltar !== 4'h0) $display("FAIL reset_soltar got=%b exp=0000", soltar); else npass++;
    repeat (3) step();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      nchecks++;
      if ({nivel, pulso, soltar} !== 12'h000)
        $display("FAIL idle_after_reset i=%0d got=%h exp=000", i, {nivel, pulso, soltar});
      else npass++;
    end
  endtask

  task automatic test_clean_press();
    botones[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      nchecks++; if (nivel !== ((i >= 5) ? 4'b0001 : 4'b0000))
        $display("FAIL press_nivel i=%0d got=%b exp=%b", i, nivel, (i >= 5) ? 4'b0001 : 4'b0000); else npass++;
      nchecks++; if (pulso !== ((i == 5) ? 4'b0001 : 4'b0000))
        $display("FAIL press_pulso i=%0d got=%b exp=%b", i, pulso, (i == 5) ? 4'b0001 : 4'b0000); else npass++;
      nchecks++; if (soltar !== 4'b0000)
        $display("FAIL press_soltar i=%0d got=%b exp=0000", i, soltar); else npass++;
    end
    botones[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      nchecks++; if (nivel !== ((i < 5) ? 4'b0001 : 4'b0000))
        $display("FAIL release_nivel i=%0d got=%b exp=%b", i, nivel, (i < 5) ? 4'b0001 : 4'b0000); else npass++;
      nchecks++; if (soltar !== ((i == 5) ? 4'b0001 : 4'b0000))
        $display("FAIL release_soltar i=%0d got=%b exp=%b", i, soltar, (i == 5) ? 4'b0001 : 4'b0000); else npass++;
      nchecks++; if (pulso !== 4'b0000)
        $display("FAIL release_pulso i=%0d got=%b exp=0000", i, pulso); else npass++;
    end
  endtask

  task automatic test_glitch();
    for (int r = 0; r < 5; r++) begin
      botones[1] = 1'b0;
      repeat (3) begin
        step();
        nchecks++; if ({nivel, pulso, soltar} !== 12'h000)
          $display("FAIL glitch_low r=%0d got=%h exp=000", r, {nivel, pulso, soltar}); else npass++;
      end
      botones[1] = 1'b1;
      repeat (3) begin
        step();
        nchecks++; if ({nivel, pulso, soltar} !== 12'h000)
          $display("FAIL glitch_high r=%0d got=%h exp=000", r, {nivel, pulso, soltar}); else npass++;
      end
    end
    repeat (6) begin
      step();
      nchecks++; if ({nivel, pulso, soltar} !== 12'h000)
        $display("FAIL glitch_tail got=%h exp=000", {nivel, pulso, soltar}); else npass++;
    end
  endtask

  // Pin held low before edges 0..39: press pulse after edge 5, repeats after
  // edges 15,20,...,40; level drops after edge 45 where a repeat is due but
  // must be suppressed.
  task automatic test_autorepeat();
    logic ep, es, en;
    botones[0] = 1'b0;
    for (int i = 0; i < 56; i++) begin
      if (i == 40) botones[0] = 1'b1;
      step();
      ep = (i == 5) || (i >= 15 && i <= 40 && ((i - 15) % 5) == 0);
      es = (i == 45);
      en = (i >= 5 && i < 45);
      nchecks++; if (pulso[0] !== ep)
        $display("FAIL repeat_pulso i=%0d got=%b exp=%b", i, pulso[0], ep); else npass++;
      nchecks++; if (soltar[0] !== es)
        $display("FAIL repeat_soltar i=%0d got=%b exp=%b", i, soltar[0], es); else npass++;
      nchecks++; if (nivel[0] !== en)
        $display("FAIL repeat_nivel i=%0d got=%b exp=%b", i, nivel[0], en); else npass++;
      nchecks++; if ({pulso[3:1], soltar[3:1], nivel[3:1]} !== 9'h000)
        $display("FAIL repeat_others i=%0d got=%h exp=000", i, {pulso[3:1], soltar[3:1], nivel[3:1]}); else npass++;
    end
  endtask

  task automatic test_unmasked();
    logic ep, es, en;
    botones[2] = 1'b0;
    for (int i = 0; i < 56; i++) begin
      if (i == 40) botones[2] = 1'b1;
      step();
      ep = (i == 5);
      es = (i == 45);
      en = (i >= 5 && i < 45);
      nchecks++; if (pulso[2] !== ep)
        $display("FAIL unmasked_pulso i=%0d got=%b exp=%b", i, pulso[2], ep); else npass++;
      nchecks++; if (soltar[2] !== es)
        $display("FAIL unmasked_soltar i=%0d got=%b exp=%b", i, soltar[2], es); else npass++;
      nchecks++; if (nivel[2] !== en)
        $display("FAIL unmasked_nivel i=%0d got=%b exp=%b", i, nivel[2], en); else npass++;
    end
  endtask

  task automatic test_reset_mid_hold();
    botones[0] = 1'b0;
    repeat (8) step();
    nchecks++; if (nivel[0] !== 1'b1)
      $display("FAIL midhold_nivel_before got=%b exp=1", nivel[0]); else npass++;
    #2 reset = 1'b0;
    #1;
    nchecks++; if (nivel  !== 4'h0) $display("FAIL midhold_async_nivel got=%b exp=0000", nivel);  else npass++;
    nchecks++; if (pulso  !== 4'h0) $display("FAIL midhold_async_pulso got=%b exp=0000", pulso);  else npass++;
    nchecks++; if (soltar !== 4'h0) $display("FAIL midhold_async_soltar got=%b exp=0000", soltar); else npass++;
    repeat (2) begin
      step();
      nchecks++; if ({nivel, pulso, soltar} !== 12'h000)
        $display("FAIL midhold_in_reset got=%h exp=000", {nivel, pulso, soltar}); else npass++;
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      nchecks++; if (pulso[0] !== (i == 5))
        $display("FAIL midhold_pulso i=%0d got=%b exp=%b", i, pulso[0], (i == 5)); else npass++;
      nchecks++; if (soltar[0] !== 1'b0)
        $display("FAIL midhold_soltar i=%0d got=%b exp=0", i, soltar[0]); else npass++;
      nchecks++; if (nivel[0] !== (i >= 5))
        $display("FAIL midhold_nivel i=%0d got=%b exp=%b", i, nivel[0], (i >= 5)); else npass++;
    end
    // Release lands on the edge where the first repeat would be due.
    botones[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      nchecks++; if (soltar[0] !== (i == 5))
        $display("FAIL midhold_release_soltar i=%0d got=%b exp=%b", i, soltar[0], (i == 5)); else npass++;
      nchecks++; if (pulso[0] !== 1'b0)
        $display("FAIL midhold_release_pulso i=%0d got=%b exp=0", i, pulso[0]); else npass++;
    end
  endtask

  task automatic test_simultaneous();
    botones[0] = 1'b0;
    botones[3] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      nchecks++; if (pulso !== ((i == 5) ? 4'b1001 : 4'b0000))
        $display("FAIL simul_pulso i=%0d got=%b exp=%b", i, pulso, (i == 5) ? 4'b1001 : 4'b0000); else npass++;
    end
    botones[0] = 1'b1;
    botones[3] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      nchecks++; if (soltar !== ((i == 5) ? 4'b1001 : 4'b0000))
        $display("FAIL simul_soltar i=%0d got=%b exp=%b", i, soltar, (i == 5) ? 4'b1001 : 4'b0000); else npass++;
      nchecks++; if (pulso !== 4'b0000)
        $display("FAIL simul_release_pulso i=%0d got=%b exp=0000", i, pulso); else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_autorepeat();
    test_unmasked();
    test_reset_mid_hold();
    test_simultaneous();
    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
